// File: rtl/mul_hilo_ctrl_if.sv
// Bus between the execute stage and the multi-cycle multiply / HI-LO unit.
// The master (pipeline) drives the launch, operand, abort and MTHI/MTLO signals.
// The slave (multiply controller) returns busy, the done pulse and HI/LO.
interface mul_hilo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_signed, a, b, abort, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op_signed, a, b, abort, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Multi-cycle MULT/MULTU controller with architectural HI/LO registers.
// The unit multiplies operand magnitudes with a radix-2 shift-add loop over WIDTH
// cycles, then applies the sign in a single FIX cycle and writes HI/LO.
// Sequence: IDLE -> CALC (WIDTH cycles) -> FIX -> DONE (one-cycle done pulse).
// MTHI/MTLO writes are taken only while the unit is not busy.
module mul_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mul_hilo_ctrl_if.slave   bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic                r_busy;
    logic                r_done;

    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  r_acc;
    logic                r_neg;

    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;

    logic                w_idle;
    logic                w_accept;
    logic                w_last;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic                w_neg;
    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_acc_shift;
    logic [2*WIDTH-1:0]  w_prod;

    // IDLE and DONE are the only states that accept a new multiply or MTHI/MTLO.
    assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = w_idle && bus.start;
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // Operand magnitudes and result sign; the most negative value maps onto itself,
    // which is correct when the magnitude is read as unsigned.
    always_comb begin
        w_a_mag = bus.a;
        w_b_mag = bus.b;
        w_neg   = 1'b0;
        if (bus.op_signed) begin
            if (bus.a[WIDTH-1]) begin
                w_a_mag = ~bus.a + WIDTH'(1);
            end
            if (bus.b[WIDTH-1]) begin
                w_b_mag = ~bus.b + WIDTH'(1);
            end
            w_neg = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end

    // One shift-add step: conditional add into the upper half with carry kept,
    // then the whole {carry, acc} shifts right by one.
    always_comb begin
        w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_mcand[0] ? {1'b0, r_mplier} : {(WIDTH+1){1'b0}});
        w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};
        w_prod      = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    end

    // Control FSM with registered busy/done; abort beats start and completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_CALC;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_last) begin
                        r_state <= S_FIX;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_count <= r_count + CW'(1);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_FIX: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand latch on launch and shift-add accumulator advance during CALC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_neg    <= w_neg;
        end else if ((r_state == S_CALC) && !bus.abort) begin
            r_mcand  <= r_mcand >> 1;
            r_acc    <= w_acc_shift;
        end
    end

    // HI/LO: written by a completed FIX cycle or by MTHI/MTLO while not busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_FIX) begin
            if (!bus.abort) begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end
        end else if (w_idle) begin
            if (bus.mthi) begin
                r_hi <= bus.wdata;
            end
            if (bus.mtlo) begin
                r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: directed corner cases plus randomized
// multiplies, compared against a reference product computed with 64-bit arithmetic.
module tb_mul_hilo_ctrl;

    localparam int W = 32;

    logic clk;
    logic reset;

    mul_hilo_ctrl_if #(.WIDTH(W)) bus ();

    mul_hilo_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic [63:0]  pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sg);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a launch; returns in cycle 1 of the multiply.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        bus.a         = a;
        bus.b         = b;
        bus.op_signed = sg;
        bus.start     = 1'b1;
        pend          = ref_prod(a, b, sg);
        tick();
        bus.start     = 1'b0;
    endtask

    // Wait for done (bounded), checking latency, busy throughout, and HI/LO.
    task automatic wait_done(input string tag, input int cyc0);
        int cyc;
        int busy_err;
        cyc      = cyc0;
        busy_err = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy !== 1'b1) busy_err++;
            tick();
            cyc++;
        end
        exp_hi = pend[63:32];
        exp_lo = pend[31:0];
        check({tag, "_cycle"}, 64'(cyc), 64'(W + 2));
        check({tag, "_busy"}, 64'(busy_err), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    task automatic after_done(input string tag);
        tick();
        check({tag, "_done_clr"}, 64'(bus.done), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic write_hilo(input logic h, input logic l, input logic [W-1:0] wd);
        bus.mthi  = h;
        bus.mtlo  = l;
        bus.wdata = wd;
        if (h) exp_hi = wd;
        if (l) exp_lo = wd;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int seen_done;
        bus.start = 1'b0; bus.op_signed = 1'b0; bus.a = '0; bus.b = '0;
        bus.abort = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0; pend = '0;
        tick(); tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;
        tick();

        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("multu_ff", 1);
        after_done("multu_ff");
        launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_done("mult_m1", 1);
        after_done("mult_m1");
        launch(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("mult_min", 1);
        after_done("mult_min");
        launch(32'hFFFF_FFFB, 32'h0, 1'b1);
        wait_done("mult_zero", 1);
        after_done("mult_zero");
        launch(32'h8000_0000, 32'h2, 1'b0);
        wait_done("multu_min2", 1);
        after_done("multu_min2");

        // MTHI together with start, then abort in cycle 10.
        bus.mthi = 1'b1; bus.wdata = 32'h1234_5678; exp_hi = 32'h1234_5678;
        launch(32'h3, 32'h5, 1'b0);
        bus.mthi = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen_done++;
            tick();
        end
        check("abort_nodone", 64'(seen_done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'(exp_hi));
        check("abort_lo", 64'(bus.lo), 64'(exp_lo));

        // Abort in the FIX cycle (cycle W+1).
        launch(32'h0000_1234, 32'h0000_5678, 1'b0);
        for (int i = 0; i < W; i++) tick();
        check("fix_busy", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("fixabort_busy", 64'(bus.busy), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done) seen_done++;
            tick();
        end
        check("fixabort_nodone", 64'(seen_done), 64'd0);
        check("fixabort_hi", 64'(bus.hi), 64'(exp_hi));
        check("fixabort_lo", 64'(bus.lo), 64'(exp_lo));

        // Start and MTLO during CALC are ignored.
        launch(32'h7, 32'h9, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        bus.start = 1'b1; bus.a = 32'hAAAA_AAAA; bus.b = 32'h5555_5555;
        bus.mtlo = 1'b1; bus.wdata = 32'h0000_DEAD;
        tick();
        bus.start = 1'b0; bus.mtlo = 1'b0;
        wait_done("ign_calc", 6);

        // Back-to-back launch from the DONE cycle.
        launch(32'hFFFF_FFF0, 32'h0000_0010, 1'b1);
        wait_done("b2b_second", 1);
        after_done("b2b_second");

        // MTHI and MTLO together, then MTLO alone.
        write_hilo(1'b1, 1'b1, 32'hCAFE_F00D);
        check("mthilo_hi", 64'(bus.hi), 64'(exp_hi));
        check("mthilo_lo", 64'(bus.lo), 64'(exp_lo));
        write_hilo(1'b0, 1'b1, 32'h0BAD_BEEF);
        check("mtlo_hi", 64'(bus.hi), 64'(exp_hi));
        check("mtlo_lo", 64'(bus.lo), 64'(exp_lo));

        // Randomized multiplies with occasional idle-time HI/LO writes.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                write_hilo(1'($urandom), 1'($urandom), W'($urandom));
                check("rnd_mt_hi", 64'(bus.hi), 64'(exp_hi));
                check("rnd_mt_lo", 64'(bus.lo), 64'(exp_lo));
            end
            launch(pick(), pick(), 1'($urandom));
            wait_done("rnd", 1);
            if ($urandom_range(0, 1) == 0) after_done("rnd");
        end
        tick();

        // Reset during CALC cycle 20.
        launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_hi = '0; exp_lo = '0;
        check("rstcalc_hi", 64'(bus.hi), 64'd0);
        check("rstcalc_lo", 64'(bus.lo), 64'd0);
        check("rstcalc_busy", 64'(bus.busy), 64'd0);
        check("rstcalc_done", 64'(bus.done), 64'd0);
        launch(32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        wait_done("post_rst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
